// File: rtl/event_stream_unpacker.sv
// Unpacks 64-bit AXI-Stream event words into validated, rate-limited events.
// Define EVENT_STATS_EN to build the saturating accepted/dropped counters.
module event_stream_unpacker #(
   parameter int unsigned INPUT_BIT_TIME = 32,
   parameter int unsigned INPUT_BIT_X    = 8,
   parameter int unsigned INPUT_BIT_Y    = 8,
   parameter int unsigned MAX_X_COORD    = 128,
   parameter int unsigned MAX_Y_COORD    = 128,
   parameter int unsigned MIN_GAP        = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [INPUT_BIT_TIME-1:0] timestamp,
   output logic [INPUT_BIT_X-1:0]    x_coord,
   output logic [INPUT_BIT_Y-1:0]    y_coord,
   output logic                      polarity,
   output logic                      is_valid,
   output logic                      sample_done,
   output logic [31:0]               accepted_count,
   output logic [31:0]               dropped_count
);

   localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [0:0] {StIdle, StGap} state_e;

   state_e                    state_q;
   logic [GapW-1:0]           gap_cnt_q;
   logic [INPUT_BIT_TIME-1:0] last_ts_q;
   logic [INPUT_BIT_TIME-1:0] ts_q;
   logic [INPUT_BIT_X-1:0]    x_q;
   logic [INPUT_BIT_Y-1:0]    y_q;
   logic                      pol_q;
   logic                      is_valid_q;
   logic                      sample_done_q;

   logic [INPUT_BIT_TIME-1:0] word_ts;
   logic [INPUT_BIT_X-1:0]    word_x;
   logic [INPUT_BIT_Y-1:0]    word_y;
   logic                      word_pol;
   logic                      word_ok;
   logic                      handshake;
   logic                      unused_bits;

   assign word_ts     = INPUT_BIT_TIME'(s_axis_tdata[63:32]);
   assign word_y      = INPUT_BIT_Y'(s_axis_tdata[23:16]);
   assign word_x      = INPUT_BIT_X'(s_axis_tdata[15:8]);
   assign word_pol    = s_axis_tdata[0];
   assign unused_bits = ^{s_axis_tdata[31:24], s_axis_tdata[7:1]};

   assign word_ok = (32'(word_x) < MAX_X_COORD) && (32'(word_y) < MAX_Y_COORD) &&
                    (word_ts >= last_ts_q);

   // Masking with reset keeps the source from handing over a word that would be discarded.
   assign s_axis_tready = (state_q == StIdle) && !reset;
   assign handshake     = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         gap_cnt_q     <= '0;
         last_ts_q     <= '0;
         ts_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         pol_q         <= 1'b0;
         is_valid_q    <= 1'b0;
         sample_done_q <= 1'b0;
      end else begin
         is_valid_q    <= 1'b0;
         sample_done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (handshake) begin
                  if (word_ok) begin
                     ts_q       <= word_ts;
                     x_q        <= word_x;
                     y_q        <= word_y;
                     pol_q      <= word_pol;
                     is_valid_q <= 1'b1;
                     last_ts_q  <= word_ts;
                     if (MIN_GAP > 1) begin
                        state_q   <= StGap;
                        gap_cnt_q <= GapW'(MIN_GAP - 1);
                     end
                  end
                  // End of sample restarts timestamp ordering, overriding the update above.
                  if (s_axis_tlast) begin
                     sample_done_q <= 1'b1;
                     last_ts_q     <= '0;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q <= GapW'(1)) begin
                  state_q   <= StIdle;
                  gap_cnt_q <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GapW'(1);
               end
            end
            default: begin
               state_q   <= StIdle;
               gap_cnt_q <= '0;
            end
         endcase
      end
   end

   assign timestamp   = ts_q;
   assign x_coord     = x_q;
   assign y_coord     = y_q;
   assign polarity    = pol_q;
   assign is_valid    = is_valid_q;
   assign sample_done = sample_done_q;

`ifdef EVENT_STATS_EN
   logic [31:0] acc_q, acc_d;
   logic [31:0] drop_q, drop_d;

   always_comb begin
      acc_d  = acc_q;
      drop_d = drop_q;
      if (handshake) begin
         if (word_ok) begin
            if (acc_q != 32'hFFFF_FFFF) acc_d = acc_q + 32'd1;
         end else begin
            if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         drop_q <= '0;
      end else begin
         acc_q  <= acc_d;
         drop_q <= drop_d;
      end
   end

   assign accepted_count = acc_q;
   assign dropped_count  = drop_q;
`else
   assign accepted_count = '0;
   assign dropped_count  = '0;
`endif

endmodule

// File: tb/tb_event_stream_unpacker.sv
// Scoreboard bench for event_stream_unpacker: directed scenarios plus randomized words
// checked against a queue-based reference model; a second instance runs with MIN_GAP=1.
module tb_event_stream_unpacker;

`ifdef EVENT_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif
   localparam int unsigned MinGap = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        tlast = 1'b0;
   logic        s_axis_tready;
   logic [31:0] timestamp;
   logic [7:0]  x_coord, y_coord;
   logic        polarity, is_valid, sample_done;
   logic [31:0] accepted_count, dropped_count;

   logic [63:0] g1_tdata = '0;
   logic        g1_tvalid = 1'b0;
   logic        g1_tready;
   logic [31:0] g1_ts;
   logic [7:0]  g1_x, g1_y;
   logic        g1_pol, g1_valid, g1_done;
   logic [31:0] g1_acc, g1_drp;

   always #5 clk = ~clk;

   event_stream_unpacker #(.MIN_GAP(MinGap)) u_dut (
      .clk(clk), .reset(reset), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .s_axis_tlast(tlast), .s_axis_tready(s_axis_tready), .timestamp(timestamp),
      .x_coord(x_coord), .y_coord(y_coord), .polarity(polarity), .is_valid(is_valid),
      .sample_done(sample_done), .accepted_count(accepted_count),
      .dropped_count(dropped_count)
   );

   event_stream_unpacker #(.MIN_GAP(1)) u_dut_gap1 (
      .clk(clk), .reset(reset), .s_axis_tdata(g1_tdata), .s_axis_tvalid(g1_tvalid),
      .s_axis_tlast(1'b0), .s_axis_tready(g1_tready), .timestamp(g1_ts),
      .x_coord(g1_x), .y_coord(g1_y), .polarity(g1_pol), .is_valid(g1_valid),
      .sample_done(g1_done), .accepted_count(g1_acc), .dropped_count(g1_drp)
   );

   typedef struct {
      int          due;
      logic [31:0] ts;
      logic [7:0]  x;
      logic [7:0]  y;
      logic        pol;
      logic        vld;
      logic        done;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          ready_cyc = 0;
   logic [31:0] m_last_ts = '0;
   logic [31:0] m_ts = '0;
   logic [7:0]  m_x = '0, m_y = '0;
   logic        m_pol = 1'b0;
   int unsigned m_acc = 0, m_drp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mk(input logic [31:0] ts, input logic [7:0] x,
                                      input logic [7:0] y, input logic p);
      logic [14:0] j;
      j = 15'($urandom);
      return {ts, j[14:7], y, x, j[6:0], p};
   endfunction

   // Reference model: one handshake in, zero or one expected output event out.
   task automatic model_hs(input logic [63:0] w, input logic last);
      logic [31:0] ts;
      logic [7:0]  x, y;
      bit          ok;
      exp_t        e;
      ts = w[63:32];
      x  = w[15:8];
      y  = w[23:16];
      ok = (x < 8'd128) && (y < 8'd128) && (ts >= m_last_ts);
      if (ok) begin
         m_ts = ts; m_x = x; m_y = y; m_pol = w[0];
         m_acc++;
         m_last_ts = ts;
         ready_cyc = cyc + MinGap;
      end else begin
         m_drp++;
      end
      if (last) m_last_ts = '0;
      if (ok || last) begin
         e.due = cyc + 1; e.ts = m_ts; e.x = m_x; e.y = m_y; e.pol = m_pol;
         e.vld = ok; e.done = last;
         q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) begin
         tests++; fails++;
         $display("FAIL missing_event: got no output, expected ts=%0d vld=%b done=%b at cycle %0d",
                  q[0].ts, q[0].vld, q[0].done, q[0].due);
         e = q.pop_front();
      end
      if (is_valid === 1'b1 || sample_done === 1'b1) begin
         if (q.size() == 0 || q[0].due != cyc) begin
            tests++; fails++;
            $display("FAIL unexpected_event: got valid=%b done=%b ts=%0d, expected none (cycle %0d)",
                     is_valid, sample_done, timestamp, cyc);
         end else begin
            e = q.pop_front();
            check("event", {timestamp, x_coord, y_coord, polarity, is_valid, sample_done},
                  {e.ts, e.x, e.y, e.pol, e.vld, e.done});
         end
      end
   end

   task automatic send(input logic [63:0] w, input logic last);
      bit   done = 0;
      int   guard = 0;
      logic exp_rdy;
      while (!done && guard < 40) begin
         @(negedge clk);
         exp_rdy = (cyc >= ready_cyc);
         tdata   = w;
         tlast   = last;
         tvalid  = exp_rdy ? 1'b1 : 1'($urandom_range(0, 1));
         check("tready", 64'(s_axis_tready), 64'(exp_rdy));
         if (exp_rdy) begin
            model_hs(w, last);
            done = 1;
         end
         guard++;
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL send_timeout: got no ready slot, expected one within 40 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         tvalid = 1'b0;
         tlast  = 1'b0;
         check("tready_idle", 64'(s_axis_tready), 64'(cyc >= ready_cyc));
      end
   endtask

   task automatic check_counts();
      check("accepted_count", 64'(accepted_count), Stats ? 64'(m_acc) : 64'd0);
      check("dropped_count", 64'(dropped_count), Stats ? 64'(m_drp) : 64'd0);
   endtask

   task automatic do_reset(input int n, input bit hold);
      @(negedge clk);
      reset     = 1'b1;
      tvalid    = hold;
      tdata     = mk(32'd60, 8'd1, 8'd1, 1'b1);
      tlast     = hold;
      g1_tvalid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("reset_ctl", {s_axis_tready, is_valid, sample_done, polarity}, '0);
         check("reset_fields", {timestamp, x_coord, y_coord}, '0);
         check("reset_counts", {accepted_count, dropped_count}, '0);
      end
      reset  = 1'b0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      ready_cyc = 0; m_last_ts = '0; m_ts = '0; m_x = '0; m_y = '0; m_pol = 1'b0;
      m_acc = 0; m_drp = 0;
      #1 check("tready_after_reset", 64'(s_axis_tready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      int rts;
      int ts;
      do_reset(3, 1'b0);

      // Single event and the tready gap after it
      send(mk(32'd100, 8'd5, 8'd7, 1'b1), 1'b0);
      idle(5);

      // Out-of-order timestamp is dropped, equal timestamp accepted
      do_reset(2, 1'b0);
      send(mk(32'd10, 8'd1, 8'd2, 1'b0), 1'b0);
      send(mk(32'd20, 8'd3, 8'd4, 1'b1), 1'b0);
      send(mk(32'd15, 8'd5, 8'd6, 1'b0), 1'b0);
      send(mk(32'd20, 8'd7, 8'd8, 1'b1), 1'b0);
      idle(5);
      check("req031_acc", 64'(accepted_count), Stats ? 64'd3 : 64'd0);
      check("req031_drp", 64'(dropped_count), Stats ? 64'd1 : 64'd0);

      // Out-of-range coordinates
      do_reset(2, 1'b0);
      send(mk(32'd1, 8'd128, 8'd0, 1'b0), 1'b0);
      send(mk(32'd2, 8'd0, 8'd200, 1'b1), 1'b0);
      idle(3);
      check("req032_drp", 64'(dropped_count), Stats ? 64'd2 : 64'd0);

      // tlast clears the timestamp floor
      do_reset(2, 1'b0);
      send(mk(32'd500, 8'd9, 8'd9, 1'b1), 1'b1);
      send(mk(32'd3, 8'd10, 8'd11, 1'b0), 1'b0);
      send(mk(32'd4, 8'd130, 8'd11, 1'b0), 1'b1);
      idle(5);
      check_counts();

      // Reset during the gap, then reset with a word offered
      do_reset(2, 1'b0);
      send(mk(32'd50, 8'd2, 8'd3, 1'b1), 1'b0);
      do_reset(2, 1'b0);
      do_reset(2, 1'b1);
      idle(3);

      rts = 1000;
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) ts = rts - int'($urandom_range(0, 30));
         else ts = rts + int'($urandom_range(0, 20));
         rts = ts;
         send(mk(32'(ts), 8'($urandom_range(0, 140)), 8'($urandom_range(0, 140)),
                 1'($urandom_range(0, 1))), 1'($urandom_range(0, 15) == 0));
         idle(int'($urandom_range(0, 2)));
         if (i % 50 == 49) begin
            idle(2);
            check_counts();
         end
      end
      idle(6);
      check_counts();
      check("queue_drained", 64'(q.size()), 64'd0);

      // MIN_GAP=1 instance streams back-to-back
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("gap1_event", {g1_ts, g1_x, g1_y, g1_pol, g1_valid, g1_done},
                  {32'((i - 1) * 3), 8'(i - 1), 8'(i), 1'((i - 1) & 1), 1'b1, 1'b0});
         end
         if (i < 8) begin
            check("gap1_tready", 64'(g1_tready), 64'd1);
            g1_tdata  = mk(32'(i * 3), 8'(i), 8'(i + 1), 1'(i & 1));
            g1_tvalid = 1'b1;
         end else begin
            g1_tvalid = 1'b0;
            check("gap1_counts", {g1_acc, g1_drp}, {Stats ? 32'd8 : 32'd0, 32'd0});
         end
      end
      @(negedge clk);
      check("gap1_quiet", {g1_valid, g1_done}, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
